muldiv_unit: RTL
================

# muldiv_unit

Multi-cycle MIPS multiply/divide unit in the EX stage, directly downstream of the register file. It consumes the RS/RT operand pair read from the register file and produces the architectural HI/LO registers for MFHI/MFLO. It is iterative (one bit per cycle) and exposes a busy/done handshake, so the hazard logic stalls dependent instructions instead of the unit adding a long combinational path.

## Interface
Parameters:
- DATA_W, 32, operand and HI/LO width; iteration count equals DATA_W

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  request a new operation; sampled only when not busy
- op_i  in  2  operation, sampled with start_i:
  - 00 MULT
  - 01 MULTU
  - 10 DIV
  - 11 DIVU
- rs_data_i  in  DATA_W  operand A (dividend/multiplicand), driven from the register file RS read port; also the MTHI/MTLO data
- rt_data_i  in  DATA_W  operand B (divisor/multiplier), driven from the register file RT read port
- mthi_i  in  1  write rs_data_i into HI
- mtlo_i  in  1  write rs_data_i into LO
- busy_o  out  1  operation in progress; the pipeline must stall MFHI/MFLO/MTHI/MTLO and new mul/div while high
- done_o  out  1  one-cycle pulse; the new HI/LO values are visible this cycle
- div_by_zero_o  out  1  one-cycle pulse coincident with done_o for DIV/DIVU with rt = 0
- hi_o  out  DATA_W  HI register
- lo_o  out  DATA_W  LO register

## Operation
- FSM states:
  - IDLE → CALC on start_i.
  - CALC → FIX after DATA_W iterations.
  - FIX → DONE.
  - DONE → IDLE, or DONE → CALC if start_i is asserted in DONE (back-to-back).
- busy_o = (state == CALC or FIX). done_o and div_by_zero_o are high only in DONE.
- Operand capture at start:
  - Signed ops (MULT, DIV) latch the magnitudes of both operands plus their sign bits.
  - Unsigned ops latch the raw values.
  - The magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- CALC, multiply: shift-add, one multiplier bit per cycle, into a 2·DATA_W accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, producing a DATA_W remainder.
- FIX, signed ops:
  - MULT: negate the product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - At the end of FIX: mul writes {HI,LO} = product; div writes LO = quotient, HI = remainder.
- Divide by zero: full latency, HI/LO unchanged, div_by_zero_o pulses with done_o.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap.
- MTHI/MTLO:
  - In IDLE or DONE, the register is written at the clock edge.
  - mthi_i and mtlo_i together write both registers.
  - start_i in the same cycle has priority; the MT writes are dropped.
  - Ignored while busy_o.
- start_i while busy_o is ignored; operands are not re-sampled.
- Reset (any state, including mid-operation): state IDLE, operation abandoned, hi_o = lo_o = 0, busy_o = done_o = div_by_zero_o = 0.

## Timing
- Cycle 0: start_i high, sampled at the end of cycle 0.
- Cycles 1..DATA_W: CALC (32 cycles at default); busy_o high.
- Cycle DATA_W+1: FIX; busy_o high; HI/LO updated at the end of this cycle.
- Cycle DATA_W+2: DONE; done_o high, new hi_o/lo_o valid, busy_o low.
- Total latency from start to done: DATA_W+2 cycles (34 at default).
- Back-to-back throughput: one op per DATA_W+2 cycles.
- MTHI/MTLO: result visible on hi_o/lo_o the cycle after the request.
- hi_o/lo_o are registered outputs, stable except on a FIX-end, MT or reset edge.

## Configuration
- MULDIV_DIV_EN defined:
  - Divider datapath and div_by_zero_o logic are compiled in.
  - All four ops behave as specified above.
- MULDIV_DIV_EN undefined:
  - No divider hardware.
  - DIV/DIVU still take the full DATA_W+2 handshake.
  - HI/LO are left unchanged; div_by_zero_o is tied 0.
  - MULT/MULTU and MTHI/MTLO are unaffected.

## Test plan
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003: done_o at cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9 (-7), rt=0x00000002: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU rs=7, rt=2 gives LO=3, HI=1.
- Divide by zero: MTLO 0x1234, then DIVU rs=5, rt=0 → done_o and div_by_zero_o pulse together at cycle 34; LO stays 0x1234, HI stays 0.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. Then MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- Busy rules: start_i and mtlo_i pulsed during cycle 10 of an operation are ignored and the original result is produced. start_i held in DONE launches the next op with no idle cycle.
- Reset mid-operation: assert rst_i at cycle 15 → next cycle busy_o=0, hi_o=lo_o=0, and no done_o ever appears for the abandoned op.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit: one bit per cycle, HI/LO registers, busy/done handshake.
// Define MULDIV_DIV_EN to compile in the restoring divider and div_by_zero_o; otherwise DIV/DIVU only run the handshake.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic              mthi_i,
    input  logic              mtlo_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              div_by_zero_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    // state | meaning
    // IDLE  | waiting for start; MTHI/MTLO accepted
    // CALC  | DATA_W shift-add / restoring-divide iterations
    // FIX   | sign correction, HI/LO written at end of cycle
    // DONE  | done pulse; MTHI/MTLO or back-to-back start accepted
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;

    state_t              state;
    logic [1:0]          op_r;
    logic                sign_a, sign_b;
    logic [DATA_W-1:0]   a_r;
    logic [2*DATA_W-1:0] acc;
    logic [CW-1:0]       cnt;
    logic                busy_r, done_r;

    logic              signed_op, start_ok;
    logic [DATA_W-1:0] rs_mag, rt_mag;
    logic [DATA_W:0]   mul_sum;
    logic [2*DATA_W-1:0] mul_next, prod_fix;

    assign signed_op = ~op_i[0];
    assign start_ok  = start_i && (state == S_IDLE || state == S_DONE);
    assign rs_mag    = (signed_op && rs_data_i[DATA_W-1]) ? -rs_data_i : rs_data_i;
    assign rt_mag    = (signed_op && rt_data_i[DATA_W-1]) ? -rt_data_i : rt_data_i;

    // acc = {partial product, remaining multiplier bits}; carry lands in the top bit after the shift
    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? a_r : {DATA_W{1'b0}})};
    assign mul_next = {mul_sum, acc[DATA_W-1:1]};
    assign prod_fix = (op_r == OP_MULT && (sign_a ^ sign_b)) ? -acc : acc;

`ifdef MULDIV_DIV_EN
    logic [DATA_W-1:0]   b_r;
    logic                dz_r;
    logic [DATA_W:0]     div_shift, div_diff;
    logic [2*DATA_W-1:0] div_next;
    logic [DATA_W-1:0]   quot_fix, rem_fix;
    logic                div_zero;

    // acc = {remainder, dividend bits still to shift in / quotient bits shifted out}
    assign div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, b_r};
    assign div_next  = div_diff[DATA_W]
                     ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                     : {div_diff[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};
    assign quot_fix  = (op_r == OP_DIV && (sign_a ^ sign_b)) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
    assign rem_fix   = (op_r == OP_DIV && sign_a) ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    assign div_zero  = (b_r == {DATA_W{1'b0}});
    assign div_by_zero_o = dz_r;
`else
    assign div_by_zero_o = 1'b0;
`endif

    assign busy_o = busy_r;
    assign done_o = done_r;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            op_r   <= 2'b00;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_r    <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
`ifdef MULDIV_DIV_EN
            b_r    <= '0;
            dz_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef MULDIV_DIV_EN
            dz_r   <= 1'b0;
`endif
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_ok) begin
                        state  <= S_CALC;
                        busy_r <= 1'b1;
                        op_r   <= op_i;
                        sign_a <= signed_op & rs_data_i[DATA_W-1];
                        sign_b <= signed_op & rt_data_i[DATA_W-1];
                        a_r    <= rs_mag;
                        acc    <= op_i[1] ? {{DATA_W{1'b0}}, rs_mag} : {{DATA_W{1'b0}}, rt_mag};
                        cnt    <= CW'(DATA_W - 1);
`ifdef MULDIV_DIV_EN
                        b_r    <= rt_mag;
`endif
                    end else begin
                        state <= S_IDLE;
                        if (mthi_i) hi_o <= rs_data_i;
                        if (mtlo_i) lo_o <= rs_data_i;
                    end
                end
                S_CALC: begin
`ifdef MULDIV_DIV_EN
                    acc <= op_r[1] ? div_next : mul_next;
`else
                    acc <= mul_next;
`endif
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    state  <= S_DONE;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                    if (!op_r[1]) begin
                        {hi_o, lo_o} <= prod_fix;
                    end
`ifdef MULDIV_DIV_EN
                    else if (!div_zero) begin
                        lo_o <= quot_fix;
                        hi_o <= rem_fix;
                    end
                    dz_r <= op_r[1] & div_zero;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
